sweep_compare_ctrl: RTL and testbench
=====================================

SWEEP_COMPARE_CTRL -- requirements
Module: sweep_compare_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning clock cycles each vector is held before sampling; legal range 1..15.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1) is the single clock, and rst_n (input, 1) is the active-low asynchronous reset.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin exhaustive sweep; sampled only in IDLE or DONE.
REQ-006 abort  input  1  synchronous sweep cancel.
REQ-007 res_in  input  3  outputs of the three implementations under comparison, bit i = implementation i.
REQ-008 vec_out  output  4  stimulus {a,b,c,d} driven to all three implementations, a = bit 3.
REQ-009 busy  output  1  sweep in progress.
REQ-010 done  output  1  sweep complete; held until next start or reset.
REQ-011 pass  output  1  valid with done; 1 = no mismatch on any vector.
REQ-012 err_count  output  5  number of mismatching vectors, 0..16.
REQ-013 first_fail_valid  output  1  at least one mismatch captured.
REQ-014 first_fail_vec  output  4  vec_out of first mismatching vector.
REQ-015 first_fail_res  output  3  res_in sampled at first mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-017 IDLE/DONE with start=1: vec_out<=0, settle counter<=SETTLE-1, err_count<=0, first_fail_* <=0, done<=0, busy<=1, go SETTLE.
REQ-018 SETTLE: counter decrements each cycle; at counter=0 go CHECK (SETTLE cycles total).
REQ-019 CHECK: sample res_in; mismatch = not all three bits equal (res_in not 3'b000 and not 3'b111).
REQ-020 On mismatch: err_count+1; if first_fail_valid=0, capture vec_out and res_in, set first_fail_valid.
REQ-021 CHECK with vec_out!=15: vec_out+1, reload counter SETTLE-1, go SETTLE.
REQ-022 CHECK with vec_out=15: go DONE; busy<=0, done<=1, pass<=(final err_count==0) including current vector's result; vec_out holds 15, no wrap.
REQ-023 Latency: start accepted at edge k -> done=1 after edge k+16*(SETTLE+1); each vector occupies SETTLE+1 cycles.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in SETTLE/CHECK: go IDLE next edge, busy<=0, done<=0, pass<=0, vec_out<=0; err_count and first_fail_* retained.
REQ-026 abort and start in same cycle in IDLE/DONE: start wins; abort in IDLE/DONE otherwise has no effect.
REQ-027 err_count SHALL saturate at 16 (structurally unreachable above 16; 5-bit width).
REQ-028 pass SHALL be 0 whenever done=0.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, first_fail_res=0, counter=0.
REQ-030 Reset asserted mid-sweep SHALL discard all progress; sweep restarts only on a new start after rst_n=1.

Verification
REQ-031 Reset: rst_n=0 mid-cycle -> all outputs 0 before next clk edge.
REQ-032 SETTLE=4, res_in = three copies of same 4-input function of vec_out, pulse start -> done=1 exactly 80 cycles after start edge, pass=1, err_count=0, first_fail_valid=0.
REQ-033 SETTLE=4, res_in[1] inverted only for vec_out=4'b0011 and 4'b1100 -> err_count=2, pass=0, first_fail_vec=4'b0011, first_fail_res=3'b010 when function output is 0.
REQ-034 res_in[0] stuck opposite to the other two -> err_count=16, pass=0, first_fail_vec=0.
REQ-035 start pulsed at vector 5 -> ignored, done timing unchanged; abort at vector 7 -> next cycle busy=0, done=0, vec_out=0, err_count retained; new start clears counts and completes normally.
REQ-036 rst_n pulsed low at vector 9 -> outputs cleared, no done until a fresh start plus 16*(SETTLE+1) cycles.

Source files
------------

// File: rtl/sweep_compare_ctrl.sv
// Exhaustive 4-input sweep comparator.
// Drives vectors 0..15 to three implementations and holds each vector for
// SETTLE cycles. On the following CHECK cycle it flags any disagreement among
// the three result bits. It counts mismatching vectors and captures the
// first failing vector along with the results seen on it.
module sweep_compare_ctrl #(
   parameter int SETTLE = 4            // hold cycles per vector, 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] res_in,
   output logic [3:0] vec_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       first_fail_valid,
   output logic [3:0] first_fail_vec,
   output logic [2:0] first_fail_res
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] settle_cnt;
   logic       mismatch;
   logic [4:0] err_after;

   // Mismatch classification and the error count this CHECK cycle would produce.
   // Saturation at 16 is a safety net; 16 vectors cannot push the count higher.
   always_comb begin
      mismatch  = (res_in != 3'b000) && (res_in != 3'b111);
      err_after = err_count;
      if (mismatch && (err_count != 5'd16))
         err_after = err_count + 5'd1;
   end

   // Sweep sequencer with registered status and capture outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         settle_cnt       <= '0;
         vec_out          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         first_fail_res   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // start takes priority over abort here; abort alone does nothing
               if (start) begin
                  state            <= ST_SETTLE;
                  settle_cnt       <= RELOAD;
                  vec_out          <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
                  first_fail_res   <= '0;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  vec_out <= '0;
               end else if (settle_cnt == 4'd0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            ST_CHECK: begin
               // An abort here drops the current vector's result uncounted
               if (abort) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  vec_out <= '0;
               end else begin
                  err_count <= err_after;
                  if (mismatch && !first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_vec   <= vec_out;
                     first_fail_res   <= res_in;
                  end
                  if (vec_out == 4'd15) begin
                     // Last vector: vec_out stays at 15, pass includes this result
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_after == 5'd0);
                  end else begin
                     state      <= ST_SETTLE;
                     vec_out    <= vec_out + 4'd1;
                     settle_cnt <= RELOAD;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_compare_ctrl.sv
// Scoreboard bench for sweep_compare_ctrl (SETTLE=4).
// Stimulus pushes the expected completion record for each sweep. A monitor
// pops one record at each rising edge of done and compares it.
module tb_sweep_compare_ctrl;

   localparam int SETTLE = 4;
   localparam int LAT    = 16 * (SETTLE + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] res_in;
   logic [3:0] vec_out;
   logic       busy, done, pass;
   logic [4:0] err_count;
   logic       first_fail_valid;
   logic [3:0] first_fail_vec;
   logic [2:0] first_fail_res;

   // 0: all agree, 1: res_in[1] flipped on vectors 3 and 12, 2: res_in[0] always opposite
   logic [1:0] mode = 2'd0;
   logic       fv;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [4:0] err;
      logic       pass;
      logic       ffv;
      logic [3:0] ffvec;
      logic [2:0] ffres;
      int         start_cyc;
   } exp_t;

   exp_t q[$];

   sweep_compare_ctrl #(.SETTLE(SETTLE)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .res_in           (res_in),
      .vec_out          (vec_out),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_vec   (first_fail_vec),
      .first_fail_res   (first_fail_res)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference function f(a,b,c,d) = a&b | c&~d. This gives f(3)=0, f(12)=1 and f(0)=0.
   function automatic logic ref_f(input logic [3:0] v);
      return (v[3] & v[2]) | (v[1] & ~v[0]);
   endfunction

   always_comb begin
      fv     = ref_f(vec_out);
      res_in = {fv, fv, fv};
      case (mode)
         2'd1: res_in = {fv, fv ^ ((vec_out == 4'd3) || (vec_out == 4'd12)), fv};
         2'd2: res_in = {fv, fv, ~fv};
         default: res_in = {fv, fv, fv};
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one comparison set per completed sweep
   logic done_prev = 1'b0;
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (done && !done_prev) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'(0));
            end else begin
               e = q.pop_front();
               chk("done_latency", 32'(cyc - e.start_cyc), 32'(LAT));
               chk("done_busy",    32'(busy), 32'(0));
               chk("done_vec",     32'(vec_out), 32'(15));
               chk("err_count",    32'(err_count), 32'(e.err));
               chk("pass",         32'(pass), 32'(e.pass));
               chk("ff_valid",     32'(first_fail_valid), 32'(e.ffv));
               chk("ff_vec",       32'(first_fail_vec), 32'(e.ffvec));
               chk("ff_res",       32'(first_fail_res), 32'(e.ffres));
               $display("[TB] sweep done: err=%0d pass=%0b ffv=%0b ffvec=%0h ffres=%0b lat=%0d",
                        err_count, pass, first_fail_valid, first_fail_vec, first_fail_res,
                        cyc - e.start_cyc);
            end
         end
         done_prev = done;
      end
   end

   // Pulse start for one edge; optionally push the expected completion record
   task automatic pulse_start(input bit push, input logic [4:0] err, input logic ps,
                              input logic ffv, input logic [3:0] ffvec,
                              input logic [2:0] ffres, input logic with_abort);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      abort = with_abort;
      if (push) begin
         e.err = err; e.pass = ps; e.ffv = ffv; e.ffvec = ffvec; e.ffres = ffres;
         e.start_cyc = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_vec(input logic [3:0] v);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (busy && vec_out == v) seen = 1'b1;
      end
      chk("wait_vec_timeout", 32'(seen), 32'(1));
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (q.size() == 0) ok = 1'b1;
      end
      chk("done_timeout", 32'(ok), 32'(1));
      if (!ok) q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"},   32'(vec_out), 32'(0));
      chk({tag, "_busy"},  32'(busy), 32'(0));
      chk({tag, "_done"},  32'(done), 32'(0));
      chk({tag, "_pass"},  32'(pass), 32'(0));
      chk({tag, "_err"},   32'(err_count), 32'(0));
      chk({tag, "_ffv"},   32'(first_fail_valid), 32'(0));
      chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'(0));
      chk({tag, "_ffres"}, 32'(first_fail_res), 32'(0));
   endtask

   initial begin
      int saw_done;

      // Power-on reset
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      $display("[TB] reset asserted, outputs checked");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // A: all agree; a start during vector 5 must be ignored
      mode = 2'd0;
      pulse_start(1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
      wait_vec(4'd5);
      pulse_start(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
      chk("start_ignored_busy", 32'(busy), 32'(1));
      chk("start_ignored_vec", 32'(vec_out), 32'(5));
      wait_drain();

      // Abort alone in DONE has no effect
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("done_abort_done", 32'(done), 32'(1));
      chk("done_abort_pass", 32'(pass), 32'(1));
      chk("done_abort_vec",  32'(vec_out), 32'(15));
      $display("[TB] abort in DONE: done=%0b pass=%0b", done, pass);

      // B: two-vector disagreement; start together with abort (start wins)
      mode = 2'd1;
      pulse_start(1'b1, 5'd2, 1'b0, 1'b1, 4'd3, 3'b010, 1'b1);
      chk("start_wins_busy", 32'(busy), 32'(1));
      chk("start_wins_done", 32'(done), 32'(0));
      chk("start_wins_pass", 32'(pass), 32'(0));
      wait_drain();

      // C: stuck-opposite bit 0 fails every vector
      mode = 2'd2;
      pulse_start(1'b1, 5'd16, 1'b0, 1'b1, 4'd0, 3'b001, 1'b0);
      wait_drain();

      // D: abort at vector 7 (vectors 0..6 already counted as errors)
      pulse_start(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
      wait_vec(4'd7);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_pass", 32'(pass), 32'(0));
      chk("abort_vec",  32'(vec_out), 32'(0));
      chk("abort_err",  32'(err_count), 32'(7));
      chk("abort_ffv",  32'(first_fail_valid), 32'(1));
      $display("[TB] abort at vec 7: busy=%0b err=%0d", busy, err_count);
      mode = 2'd0;
      pulse_start(1'b1, 5'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0);
      chk("restart_err_clr", 32'(err_count), 32'(0));
      chk("restart_ffv_clr", 32'(first_fail_valid), 32'(0));
      wait_drain();

      // E: reset mid-cycle at vector 9, then no done without a fresh start
      mode = 2'd2;
      pulse_start(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0);
      wait_vec(4'd9);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      $display("[TB] mid-sweep reset at vec 9 checked");
      @(negedge clk); rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done || busy) saw_done++;
      end
      chk("no_done_after_reset", 32'(saw_done), 32'(0));
      pulse_start(1'b1, 5'd16, 1'b0, 1'b1, 4'd0, 3'b001, 1'b0);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
